step_pulse_gen: RTL and testbench

//  Stepper-motor pulse generator; sits directly downstream of the tracking controller.

---
 rtl/tr_pkg.sv | 31 +++
 rtl/step_pulse_gen_if.sv | 28 ++
 rtl/step_timer.sv | 34 +++
 rtl/step_pulse_gen.sv | 150 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tr_pkg.sv
// Tracking-drive shared definitions: widths, 50 MHz
// timing constants and stepper FSM state encoding.
package tr_pkg;

  localparam int WIDTH_WORK = 16;
  localparam int POS_W      = 32;

  localparam int PULSE_W    = 100;
  localparam int DIR_SETUP  = 250;
  localparam int MIN_PERIOD = 250;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_HIGH  = ST_HIGH,
    S_LOW   = ST_LOW
  } state_e;

  function automatic logic [WIDTH_WORK-1:0] clamp_period(
    input logic [WIDTH_WORK-1:0] p,
    input logic [WIDTH_WORK-1:0] lo
  );
    return (p < lo) ? lo : p;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Command/pin bundle between tracking controller,
// step pulse generator and the driver IC pins.
interface step_pulse_gen_if;
  import tr_pkg::*;

  logic                         enable;
  logic                         dir_req;
  logic [WIDTH_WORK-1:0]        period;
  logic                         step;
  logic                         dir;
  logic                         drv_en;
  logic                         busy;
  logic                         step_strobe;
  logic signed [POS_W-1:0]      pos;

  modport master (
    output enable, dir_req, period,
    input  step, dir, drv_en, busy,
    input  step_strobe, pos
  );

  modport slave (
    input  enable, dir_req, period,
    output step, dir, drv_en, busy,
    output step_strobe, pos
  );

endinterface

// File: rtl/step_timer.sv
// Loadable down-counter with zero flag; holds at
// zero so a missed decrement can never wrap.
module step_timer
  import tr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [WIDTH_WORK-1:0] val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [WIDTH_WORK-1:0] cnt_q, cnt_d;

  // load has priority over decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH_WORK'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR/EN generator with fixed pulse width,
// direction setup time and signed position count.
module step_pulse_gen #(
  parameter int PULSE_W    = tr_pkg::PULSE_W,
  parameter int DIR_SETUP  = tr_pkg::DIR_SETUP,
  parameter int MIN_PERIOD = tr_pkg::MIN_PERIOD
) (
  input logic            clk,
  input logic            rst,
  step_pulse_gen_if.slave bus
);

  localparam int WW = tr_pkg::WIDTH_WORK;
  localparam int PW = tr_pkg::POS_W;

  localparam logic [WW-1:0] LD_SETUP =
    WW'(DIR_SETUP - 1);
  localparam logic [WW-1:0] LD_HIGH =
    WW'(PULSE_W - 1);
  localparam logic [WW-1:0] LO_OFS =
    WW'(PULSE_W + 1);
  localparam logic [WW-1:0] P_MIN =
    WW'(MIN_PERIOD);

  tr_pkg::state_e state_q, state_d;

  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          stb_q, stb_d;
  logic          en_q, en_d;
  logic [WW-1:0] plat_q, plat_d;
  logic [PW-1:0] pos_q, pos_d;

  logic          ld;
  logic [WW-1:0] ld_val;
  logic          dec;
  logic          zero;

  step_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .val_i  (ld_val),
    .dec_i  (dec),
    .zero_o (zero)
  );

  // next state, counter control and pin values
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    plat_d  = plat_q;
    pos_d   = pos_q;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    unique case (state_q)
      tr_pkg::S_IDLE: begin
        if (bus.enable && bus.period != '0) begin
          dir_d   = bus.dir_req;
          ld      = 1'b1;
          ld_val  = LD_SETUP;
          state_d = tr_pkg::S_SETUP;
        end
      end
      tr_pkg::S_SETUP: begin
        if (!bus.enable) begin
          state_d = tr_pkg::S_IDLE;
        end else if (zero) begin
          plat_d  = tr_pkg::clamp_period(
                      bus.period, P_MIN);
          ld      = 1'b1;
          ld_val  = LD_HIGH;
          state_d = tr_pkg::S_HIGH;
        end else begin
          dec = 1'b1;
        end
      end
      tr_pkg::S_HIGH: begin
        if (!zero) begin
          dec = 1'b1;
        end else if (!bus.enable) begin
          state_d = tr_pkg::S_IDLE;
        end else begin
          ld      = 1'b1;
          ld_val  = plat_q - LO_OFS;
          state_d = tr_pkg::S_LOW;
        end
      end
      tr_pkg::S_LOW: begin
        if (!bus.enable) begin
          state_d = tr_pkg::S_IDLE;
        end else if (!zero) begin
          dec = 1'b1;
        end else if (bus.period == '0) begin
          state_d = tr_pkg::S_IDLE;
        end else if (bus.dir_req != dir_q) begin
          dir_d   = bus.dir_req;
          ld      = 1'b1;
          ld_val  = LD_SETUP;
          state_d = tr_pkg::S_SETUP;
        end else begin
          plat_d  = tr_pkg::clamp_period(
                      bus.period, P_MIN);
          ld      = 1'b1;
          ld_val  = LD_HIGH;
          state_d = tr_pkg::S_HIGH;
        end
      end
      default: state_d = tr_pkg::S_IDLE;
    endcase
    step_d = (state_d == tr_pkg::S_HIGH);
    stb_d  = step_d &&
             (state_q != tr_pkg::S_HIGH);
    en_d   = (state_d != tr_pkg::S_IDLE);
    if (stb_d) begin
      pos_d = dir_q ? pos_q + PW'(1)
                    : pos_q - PW'(1);
    end
  end

  // state and registered pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= tr_pkg::S_IDLE;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      stb_q   <= 1'b0;
      en_q    <= 1'b0;
      plat_q  <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      stb_q   <= stb_d;
      en_q    <= en_d;
      plat_q  <= plat_d;
      pos_q   <= pos_d;
    end
  end

  assign bus.step        = step_q;
  assign bus.dir         = dir_q;
  assign bus.drv_en      = en_q;
  assign bus.busy        = en_q;
  assign bus.step_strobe = stb_q;
  assign bus.pos         = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with a strobe
// scoreboard of expected rise cycle and position.
module tb_step_pulse_gen;

  localparam int PW = 4;

  typedef struct {
    int          cyc;
    logic [31:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hi_len = 0;
  int   t0;
  exp_t sb[$];

  step_pulse_gen_if bus ();

  step_pulse_gen #(
    .PULSE_W    (4),
    .DIR_SETUP  (6),
    .MIN_PERIOD (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int c,
                      input logic [31:0] p);
    exp_t e;
    e.cyc = c;
    e.pos = p;
    sb.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (bus.step === 1'b1) begin
      hi_len++;
    end else begin
      if (hi_len != 0) chk("pulse_w", hi_len, PW);
      hi_len = 0;
    end
    if (bus.step_strobe === 1'b1) begin
      chk("stb_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stb_cyc", cyc, e.cyc);
        chk("stb_pos", bus.pos, e.pos);
      end
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      mon();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.dir_req = 1'b0;
    bus.period  = '0;
    repeat (3) @(negedge clk);
    chk("rst_step", bus.step, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_drv_en", bus.drv_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stb", bus.step_strobe, 0);
    chk("rst_pos", bus.pos, 0);
    rst = 1'b0;
    adv(2);

    // reset in the middle of a STEP pulse
    t0 = cyc;
    bus.enable  = 1'b1;
    bus.dir_req = 1'b1;
    bus.period  = 16'd20;
    push(t0 + 7, 32'd1);
    adv(8);
    chk("t1_step_hi", bus.step, 1);
    rst        = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("t1_async_step", bus.step, 0);
    chk("t1_async_dir", bus.dir, 0);
    chk("t1_async_en", bus.drv_en, 0);
    chk("t1_async_busy", bus.busy, 0);
    chk("t1_async_pos", bus.pos, 0);
    hi_len = 0;
    adv(1);
    rst = 1'b0;
    adv(3);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_step", bus.step, 0);

    // steady run, then clamp, then stop
    t0 = cyc;
    bus.enable  = 1'b1;
    bus.dir_req = 1'b1;
    bus.period  = 16'd20;
    push(t0 + 7, 32'd1);
    push(t0 + 27, 32'd2);
    push(t0 + 47, 32'd3);
    chk("t2_en_pre", bus.drv_en, 0);
    adv(1);
    chk("t2_drv_en", bus.drv_en, 1);
    chk("t2_busy", bus.busy, 1);
    chk("t2_dir", bus.dir, 1);
    chk("t2_step_lo", bus.step, 0);
    adv(47);
    chk("t2_pos3", bus.pos, 3);
    bus.period = 16'd3;
    push(t0 + 67, 32'd4);
    push(t0 + 77, 32'd5);
    adv(32);
    bus.period = '0;
    adv(6);
    chk("t3_busy_last", bus.busy, 1);
    adv(1);
    chk("t3_stop_busy", bus.busy, 0);
    chk("t3_stop_en", bus.drv_en, 0);
    adv(2);
    chk("t3_pos5", bus.pos, 5);

    // direction reversal in the LOW phase
    t0 = cyc;
    bus.period  = 16'd20;
    bus.dir_req = 1'b1;
    push(t0 + 7, 32'd6);
    adv(12);
    bus.dir_req = 1'b0;
    push(t0 + 33, 32'd5);
    push(t0 + 53, 32'd4);
    adv(14);
    chk("t4_dir_old", bus.dir, 1);
    adv(1);
    chk("t4_dir_new", bus.dir, 0);
    chk("t4_step_lo", bus.step, 0);
    chk("t4_busy", bus.busy, 1);
    adv(26);

    // enable drops one cycle into HIGH
    bus.enable = 1'b0;
    adv(3);
    chk("t5_step_held", bus.step, 1);
    adv(1);
    chk("t5_step_end", bus.step, 0);
    chk("t5_drv_en", bus.drv_en, 0);
    chk("t5_busy", bus.busy, 0);

    // enable drops during SETUP
    bus.enable  = 1'b1;
    bus.dir_req = 1'b1;
    adv(3);
    chk("t5_setup_busy", bus.busy, 1);
    bus.enable = 1'b0;
    adv(9);
    chk("t5_abort_busy", bus.busy, 0);
    chk("t5_abort_pos", bus.pos, 4);

    // position wrap
    force dut.pos_q = 32'h7FFF_FFFF;
    adv(1);
    release dut.pos_q;
    adv(1);
    chk("t6_preset", bus.pos, 32'h7FFF_FFFF);
    t0 = cyc;
    bus.enable = 1'b1;
    push(t0 + 7, 32'h8000_0000);
    adv(8);
    bus.enable = 1'b0;
    adv(5);
    chk("t6_wrap", bus.pos, 32'h8000_0000);
    chk("t6_idle", bus.busy, 0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
